// File: rtl/regfile_scoreboard.sv
// Register file with two async read ports, one sync write port and a per-register
// busy scoreboard (reserve at issue, release at writeback) for hazard stalls.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_busy1,
    output logic              o_busy2,
    input  logic              i_rsv_en,
    input  logic [ADDR_W-1:0] i_rsv_addr,
    output logic              o_rsv_conflict,
    input  logic              i_flush,
    output logic [ADDR_W:0]   o_busy_count
);
    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_count;
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_wr_ok;
    logic              w_rsv_ok;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_hit_rsv;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [ADDR_W:0] popcnt(input logic [NREGS-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++)
            c = c + (ADDR_W+1)'(v[i]);
        return c;
    endfunction

    assign w_wr_ok  = i_wr_en  && writable(i_wr_addr);
    assign w_rsv_ok = i_rsv_en && writable(i_rsv_addr);

    // Later assignments win: flush > reserve > release > hold.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)
            w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_rsv_ok)
            w_busy_nxt[i_rsv_addr] = 1'b1;
        if (i_flush)
            w_busy_nxt = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_ok)
                r_regs[i_wr_addr] <= i_wr_data;
            r_busy       <= w_busy_nxt;
            r_busy_count <= popcnt(w_busy_nxt);
        end
    end

    // A same-cycle write to a read address is forwarded and hides its busy bit.
    assign w_hit1    = (BYPASS != 0) && w_wr_ok && (i_wr_addr == i_rd_addr1);
    assign w_hit2    = (BYPASS != 0) && w_wr_ok && (i_wr_addr == i_rd_addr2);
    assign w_hit_rsv = (BYPASS != 0) && w_wr_ok && (i_wr_addr == i_rsv_addr);

    always_comb begin
        o_rd_data1 = '0;
        o_rd_data2 = '0;
        if (writable(i_rd_addr1))
            o_rd_data1 = w_hit1 ? i_wr_data : r_regs[i_rd_addr1];
        if (writable(i_rd_addr2))
            o_rd_data2 = w_hit2 ? i_wr_data : r_regs[i_rd_addr2];
    end

    assign o_busy1        = writable(i_rd_addr1) && !w_hit1 && r_busy[i_rd_addr1];
    assign o_busy2        = writable(i_rd_addr2) && !w_hit2 && r_busy[i_rd_addr2];
    assign o_rsv_conflict = i_rsv_en && writable(i_rsv_addr) && !w_hit_rsv && r_busy[i_rsv_addr];
    assign o_busy_count   = r_busy_count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a default build (bypass, hard-wired r0) and a build with
// neither feature share stimulus; expectations are queued and drained per step.
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en, rsv_en, flush;
    logic [4:0]  wr_addr, rd_addr1, rd_addr2, rsv_addr;
    logic [31:0] wr_data;

    logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
    logic        busy1, busy2, conf, nb_busy1, nb_busy2, nb_conf;
    logic [5:0]  cnt, nb_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];

    always #5 clock = ~clock;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clock(clock), .reset(reset),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(rd1), .o_rd_data2(rd2), .o_busy1(busy1), .o_busy2(busy2),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_conflict(conf),
        .i_flush(flush), .o_busy_count(cnt)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(0)) u_nb (
        .clock(clock), .reset(reset),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_data1(nb_rd1), .o_rd_data2(nb_rd2), .o_busy1(nb_busy1), .o_busy2(nb_busy2),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_conflict(nb_conf),
        .i_flush(flush), .o_busy_count(nb_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:  return rd1;
            1:  return rd2;
            2:  return 32'(busy1);
            3:  return 32'(busy2);
            4:  return 32'(conf);
            5:  return 32'(cnt);
            6:  return nb_rd1;
            7:  return nb_rd2;
            8:  return 32'(nb_busy1);
            9:  return 32'(nb_busy2);
            10: return 32'(nb_conf);
            default: return 32'(nb_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.sel = sel; x.exp = e;
        q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        #1;
        while (q.size() > 0) begin
            x = q.pop_front();
            chk(x.tag, observe(x.sel), x.exp);
        end
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; flush = 0;
        wr_addr = 0; wr_data = 0; rsv_addr = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        rd_addr1 = 0; rd_addr2 = 0;
        reset = 1;
        #3;
        push("rst_rd1", 0, 0); push("rst_busy1", 2, 0); push("rst_cnt", 5, 0);
        push("rst_conf", 4, 0); push("nb_rst_cnt", 11, 0);
        drain();
        #4 reset = 0;
        tick();

        // Write / readback
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        tick(); idle();
        rd_addr1 = 5;
        push("wr_rd1", 0, 32'hDEADBEEF); push("wr_busy1", 2, 0);
        drain();

        // Zero register: main DUT ignores r0, the other build treats it as ordinary
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rsv_en = 1; rsv_addr = 0;
        tick(); idle();
        rd_addr1 = 0;
        push("z_rd1", 0, 0); push("z_busy1", 2, 0); push("z_cnt", 5, 0);
        push("nb_z_rd1", 6, 32'h1234); push("nb_z_busy1", 8, 1); push("nb_z_cnt", 11, 1);
        drain();
        wr_en = 1; wr_addr = 0; wr_data = 0;
        tick(); idle();
        push("nb_z_rel_cnt", 11, 0);
        drain();

        // Bypass: r7=0x11 and busy, then write 0x22 while reading it
        wr_en = 1; wr_addr = 7; wr_data = 32'h11;
        tick(); idle();
        rsv_en = 1; rsv_addr = 7;
        tick(); idle();
        rd_addr2 = 7;
        wr_en = 1; wr_addr = 7; wr_data = 32'h22;
        push("byp_rd2", 1, 32'h22); push("byp_busy2", 3, 0);
        push("nb_byp_rd2", 7, 32'h11); push("nb_byp_busy2", 9, 1);
        drain();
        tick(); idle();
        push("byp_post_rd2", 1, 32'h22); push("nb_post_rd2", 7, 32'h22);
        push("nb_post_busy2", 9, 0); push("byp_post_cnt", 5, 0);
        drain();

        // Scoreboard reserve / conflict / release
        rsv_en = 1; rsv_addr = 3;
        push("sb_first_conf", 4, 0);
        drain();
        tick(); idle();
        rd_addr1 = 3;
        push("sb_busy1", 2, 1); push("sb_cnt1", 5, 1);
        drain();
        rsv_en = 1; rsv_addr = 3;
        push("sb_conf", 4, 1); push("nb_sb_conf", 10, 1);
        drain();
        tick(); idle();
        push("sb_cnt_hold", 5, 1); push("sb_busy_hold", 2, 1);
        drain();
        wr_en = 1; wr_addr = 3; wr_data = 32'h33;
        tick(); idle();
        push("sb_rel_busy1", 2, 0); push("sb_rel_cnt", 5, 0); push("sb_rel_rd1", 0, 32'h33);
        drain();
        // Releasing a clear register changes nothing
        wr_en = 1; wr_addr = 12; wr_data = 32'hC;
        tick(); idle();
        push("rel_clear_cnt", 5, 0);
        drain();

        // Simultaneous reserve + write on a busy register
        rsv_en = 1; rsv_addr = 9;
        tick(); idle();
        rsv_en = 1; rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h55;
        push("sim_conf_masked", 4, 0); push("nb_sim_conf", 10, 1);
        drain();
        tick(); idle();
        rd_addr1 = 9;
        push("sim_rd1", 0, 32'h55); push("sim_busy1", 2, 1); push("sim_cnt", 5, 1);
        drain();

        // Flush with reserve r4 and write r6
        flush = 1; rsv_en = 1; rsv_addr = 4; wr_en = 1; wr_addr = 6; wr_data = 32'h66;
        tick(); idle();
        rd_addr1 = 6; rd_addr2 = 4;
        push("fl_cnt", 5, 0); push("fl_rd1", 0, 32'h66); push("fl_busy1", 2, 0);
        push("fl_busy2", 3, 0); push("nb_fl_cnt", 11, 0);
        drain();

        // Fill r1..r31 with data and busy, then async reset between edges
        for (int i = 1; i < 32; i++) begin
            wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h101;
            rsv_en = 1; rsv_addr = 5'(i);
            tick();
        end
        idle();
        rd_addr1 = 31; rd_addr2 = 17;
        push("fill_cnt", 5, 31); push("fill_rd1", 0, 32'h1F1F);
        push("fill_busy1", 2, 1); push("fill_rd2", 1, 32'h1111); push("nb_fill_cnt", 11, 31);
        drain();
        #1 reset = 1;
        push("ar_rd1", 0, 0); push("ar_rd2", 1, 0); push("ar_busy1", 2, 0);
        push("ar_busy2", 3, 0); push("ar_cnt", 5, 0); push("nb_ar_cnt", 11, 0);
        drain();
        #1 reset = 0;
        tick();
        push("post_rst_cnt", 5, 0); push("post_rst_rd1", 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
